// File: rtl/dmglcd_pkg.sv
// ============================================================================
// Module      : dmglcd_pkg
// Description : Shared types and panel constants for the DMG LCD path.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package dmglcd_pkg;

    localparam int DMG_WIDTH  = 160;
    localparam int DMG_HEIGHT = 144;

    typedef logic [1:0] pix_t;

    typedef enum logic [1:0] {
        SEEK   = 2'd0,
        LWAIT  = 2'd1,
        ACTIVE = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/dmglcd_capture_if.sv
// ============================================================================
// Module      : dmglcd_capture_if
// Description : LCD pin bundle in, decoded pixel/status strobes out.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface dmglcd_capture_if;

    logic              lcd_cp;
    logic              lcd_st;
    logic              lcd_cpl;
    logic              lcd_s;
    dmglcd_pkg::pix_t  lcd_ld;

    logic              pix_valid;
    logic [7:0]        pix_x;
    logic [7:0]        pix_y;
    dmglcd_pkg::pix_t  pix_value;
    logic              line_done;
    logic              frame_start;
    logic              err_overrun;
    logic              err_short;
    logic              err_vsync;

    modport slave (
        input  lcd_cp, lcd_st, lcd_cpl, lcd_s, lcd_ld,
        output pix_valid, pix_x, pix_y, pix_value,
        output line_done, frame_start, err_overrun, err_short, err_vsync
    );

    modport master (
        output lcd_cp, lcd_st, lcd_cpl, lcd_s, lcd_ld,
        input  pix_valid, pix_x, pix_y, pix_value,
        input  line_done, frame_start, err_overrun, err_short, err_vsync
    );

endinterface

`default_nettype wire

// File: rtl/dmglcd_sync.sv
// ============================================================================
// Module      : dmglcd_sync
// Description : N-flop synchronizer for one async bit with rise/fall detect.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module dmglcd_sync #(
    parameter int STAGES = 2
) (
    input  wire  logic clk,
    input  wire  logic reset_n,
    input  wire  logic i_d,
    output logic       o_q,
    output logic       o_rise,
    output logic       o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_hist;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '0;
            r_hist <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
            r_hist <= r_sync[STAGES-1];
        end
    end

    assign o_q    = r_sync[STAGES-1];
    assign o_rise =  r_sync[STAGES-1] & ~r_hist;
    assign o_fall = ~r_sync[STAGES-1] &  r_hist;

endmodule

`default_nettype wire

// File: rtl/dmglcd_capture.sv
// ============================================================================
// Module      : dmglcd_capture
// Description : Decodes snooped DMG LCD pins back into pixel writes (x,y,value)
//               with line/frame boundary and protocol error strobes.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module dmglcd_capture
    import dmglcd_pkg::*;
#(
    parameter int WIDTH       = DMG_WIDTH,
    parameter int HEIGHT      = DMG_HEIGHT,
    parameter int SYNC_STAGES = 2
) (
    input  wire logic       clk,
    input  wire logic       reset_n,
    dmglcd_capture_if.slave bus
);

    logic w_cp_rise,  w_cp_fall,  w_cp_q;
    logic w_st_rise,  w_st_fall,  w_st_q;
    logic w_cpl_rise, w_cpl_fall, w_cpl_q;
    logic w_s_rise,   w_s_fall,   w_s;
    pix_t w_ld, w_ld_rise, w_ld_fall;

    // Every pin shares the same synchronizer depth so LD stays aligned to CP.
    dmglcd_sync #(.STAGES(SYNC_STAGES)) u_sync_cp (
        .clk(clk), .reset_n(reset_n), .i_d(bus.lcd_cp),
        .o_q(w_cp_q), .o_rise(w_cp_rise), .o_fall(w_cp_fall));
    dmglcd_sync #(.STAGES(SYNC_STAGES)) u_sync_st (
        .clk(clk), .reset_n(reset_n), .i_d(bus.lcd_st),
        .o_q(w_st_q), .o_rise(w_st_rise), .o_fall(w_st_fall));
    dmglcd_sync #(.STAGES(SYNC_STAGES)) u_sync_cpl (
        .clk(clk), .reset_n(reset_n), .i_d(bus.lcd_cpl),
        .o_q(w_cpl_q), .o_rise(w_cpl_rise), .o_fall(w_cpl_fall));
    dmglcd_sync #(.STAGES(SYNC_STAGES)) u_sync_s (
        .clk(clk), .reset_n(reset_n), .i_d(bus.lcd_s),
        .o_q(w_s), .o_rise(w_s_rise), .o_fall(w_s_fall));

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ld
            dmglcd_sync #(.STAGES(SYNC_STAGES)) u_sync_ld (
                .clk(clk), .reset_n(reset_n), .i_d(bus.lcd_ld[gi]),
                .o_q(w_ld[gi]), .o_rise(w_ld_rise[gi]), .o_fall(w_ld_fall[gi]));
        end
    endgenerate

    logic w_unused_edges;
    assign w_unused_edges = &{1'b0, w_cp_rise, w_cp_q, w_st_fall, w_st_q,
                              w_cpl_fall, w_cpl_q, w_s_rise, w_s_fall,
                              w_ld_rise, w_ld_fall};

    state_e     r_state;
    logic [8:0] r_x;
    logic [7:0] r_y;
    logic       r_pix_valid;
    logic [7:0] r_pix_x;
    logic [7:0] r_pix_y;
    pix_t       r_pix_value;
    logic       r_line_done;
    logic       r_frame_start;
    logic       r_err_overrun;
    logic       r_err_short;
    logic       r_err_vsync;

    logic       w_px_ok;
    logic       w_take;
    logic [8:0] w_x_post;
    logic       w_y_last;
    logic       w_advance;

    // err_short on a line end is judged against x after any same-cycle pixel.
    always_comb begin
        w_px_ok   = (r_x < 9'(WIDTH));
        w_take    = (r_state == ACTIVE) && w_cp_fall && w_px_ok;
        w_x_post  = r_x + 9'(w_take);
        w_y_last  = (r_y == 8'(HEIGHT - 1));
        w_advance = w_cpl_rise && (r_state != SEEK);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= SEEK;
            r_x           <= '0;
            r_y           <= '0;
            r_pix_valid   <= 1'b0;
            r_pix_x       <= '0;
            r_pix_y       <= '0;
            r_pix_value   <= '0;
            r_line_done   <= 1'b0;
            r_frame_start <= 1'b0;
            r_err_overrun <= 1'b0;
            r_err_short   <= 1'b0;
            r_err_vsync   <= 1'b0;
        end else begin
            r_pix_valid   <= 1'b0;
            r_pix_x       <= '0;
            r_pix_y       <= '0;
            r_pix_value   <= '0;
            r_line_done   <= 1'b0;
            r_frame_start <= 1'b0;
            r_err_overrun <= 1'b0;
            r_err_short   <= 1'b0;
            r_err_vsync   <= 1'b0;

            unique case (r_state)
                SEEK: begin
                    if (w_cpl_rise && w_s) begin
                        r_y           <= '0;
                        r_frame_start <= 1'b1;
                        r_state       <= LWAIT;
                    end
                end
                LWAIT: begin
                    if (w_cpl_rise) begin
                        r_line_done <= 1'b1;
                        r_err_short <= 1'b1;
                    end else if (w_st_rise) begin
                        r_x     <= '0;
                        r_state <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (w_take) begin
                        r_pix_valid <= 1'b1;
                        r_pix_x     <= r_x[7:0];
                        r_pix_y     <= r_y;
                        r_pix_value <= w_ld;
                    end else if (w_cp_fall) begin
                        r_err_overrun <= 1'b1;
                    end
                    r_x <= w_x_post;
                    if (w_cpl_rise) begin
                        r_line_done <= 1'b1;
                        r_err_short <= (w_x_post != 9'(WIDTH));
                        r_state     <= LWAIT;
                    end else if (w_st_rise) begin
                        r_x         <= '0;
                        r_err_short <= 1'b1;
                    end
                end
                default: r_state <= SEEK;
            endcase

            // Placed after the case so a vsync failure overrides the LWAIT move.
            if (w_advance) begin
                if (w_s) begin
                    r_y           <= '0;
                    r_frame_start <= 1'b1;
                end else if (!w_y_last) begin
                    r_y <= r_y + 8'd1;
                end else begin
                    r_err_vsync <= 1'b1;
                    r_state     <= SEEK;
                end
            end
        end
    end

    assign bus.pix_valid   = r_pix_valid;
    assign bus.pix_x       = r_pix_x;
    assign bus.pix_y       = r_pix_y;
    assign bus.pix_value   = r_pix_value;
    assign bus.line_done   = r_line_done;
    assign bus.frame_start = r_frame_start;
    assign bus.err_overrun = r_err_overrun;
    assign bus.err_short   = r_err_short;
    assign bus.err_vsync   = r_err_vsync;

endmodule

`default_nettype wire

// File: tb/tb_dmglcd_capture.sv
// ============================================================================
// Module      : tb_dmglcd_capture
// Description : Randomized pin-level stimulus against an event-level model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_dmglcd_capture;

    localparam int W = 20;
    localparam int H = 6;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    dmglcd_capture_if bus();

    dmglcd_capture #(.WIDTH(W), .HEIGHT(H), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus));

    int n_cmp  = 0;
    int n_fail = 0;

    // Record: [23]=pix_valid [22:15]=x [14:7]=y [6:5]=value
    //         [4]=line_done [3]=frame_start [2]=overrun [1]=short [0]=vsync
    logic [23:0] exp_q[$];

    typedef enum {M_HUNT, M_IDLE, M_LINE} mode_e;
    mode_e mode = M_HUNT;
    int    mx   = 0;
    int    my   = 0;

    function automatic logic [23:0] raw_obs();
        return {bus.pix_valid, bus.pix_x, bus.pix_y, bus.pix_value,
                bus.line_done, bus.frame_start, bus.err_overrun,
                bus.err_short, bus.err_vsync};
    endfunction

    function automatic logic [23:0] masked_obs();
        logic [23:0] r = raw_obs();
        if (r[23] !== 1'b1) r[22:5] = '0;
        return r;
    endfunction

    function automatic logic [23:0] m_cp(input logic [1:0] ld);
        logic [23:0] r = '0;
        if (mode == M_LINE) begin
            if (mx < W) begin
                r = {1'b1, 8'(mx), 8'(my), ld, 5'b0};
                mx++;
            end else begin
                r[2] = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic logic [23:0] m_st();
        logic [23:0] r = '0;
        if (mode == M_IDLE) begin
            mx = 0;
            mode = M_LINE;
        end else if (mode == M_LINE) begin
            mx = 0;
            r[1] = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [23:0] m_cpl(input bit s, input logic [23:0] base);
        logic [23:0] r = base;
        if (mode == M_HUNT) begin
            if (s) begin
                my = 0;
                r[3] = 1'b1;
                mode = M_IDLE;
            end
            return r;
        end
        r[4] = 1'b1;
        r[1] = (mode == M_IDLE) || (mx != W);
        mode = M_IDLE;
        if (s) begin
            my = 0;
            r[3] = 1'b1;
        end else if (my < H - 1) begin
            my++;
        end else begin
            r[0] = 1'b1;
            mode = M_HUNT;
        end
        return r;
    endfunction

    function automatic void push(input logic [23:0] r);
        if (r != 24'h0) exp_q.push_back(r);
    endfunction

    // Every output strobe cycle is matched in order against the model's events.
    always @(negedge clk) begin
        if (reset_n) begin
            logic [23:0] obs;
            logic [23:0] exp;
            obs = masked_obs();
            if (obs !== 24'h0) begin
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : 24'h0;
                n_cmp++;
                assert (obs === exp) else begin
                    n_fail++;
                    $error("FAIL event t=%0t observed=%h expected=%h", $time, obs, exp);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic cp_px();
        bus.lcd_ld = 2'($urandom_range(0, 3));
        bus.lcd_cp = 1'b1;
        tick(2 + $urandom_range(0, 1));
        bus.lcd_cp = 1'b0;
        push(m_cp(bus.lcd_ld));
        tick(2);
    endtask

    task automatic st_pulse();
        bus.lcd_st = 1'b1;
        push(m_st());
        tick(2);
        bus.lcd_st = 1'b0;
        tick(2);
    endtask

    task automatic cpl_pulse(input bit s);
        bus.lcd_s = s;
        tick(2);
        bus.lcd_cpl = 1'b1;
        push(m_cpl(s, 24'h0));
        tick(2);
        bus.lcd_cpl = 1'b0;
        tick(2);
    endtask

    task automatic cp_cpl_same(input bit s);
        logic [23:0] r;
        bus.lcd_ld = 2'($urandom_range(0, 3));
        bus.lcd_s  = s;
        bus.lcd_cp = 1'b1;
        tick(2);
        bus.lcd_cp  = 1'b0;
        bus.lcd_cpl = 1'b1;
        r = m_cp(bus.lcd_ld);
        push(m_cpl(s, r));
        tick(2);
        bus.lcd_cpl = 1'b0;
        tick(2);
    endtask

    task automatic line(input int n, input bit s);
        st_pulse();
        repeat (n) cp_px();
        cpl_pulse(s);
    endtask

    task automatic check_idle(input string tag);
        n_cmp++;
        assert (raw_obs() === 24'h0) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=000000", tag, raw_obs());
        end
    endtask

    task automatic check_drained(input string tag);
        n_cmp++;
        assert (exp_q.size() === 0) else begin
            n_fail++;
            $error("FAIL %s pending_events=%0d expected=0", tag, exp_q.size());
        end
    endtask

    initial begin
        bus.lcd_cp  = 1'b0;
        bus.lcd_st  = 1'b0;
        bus.lcd_cpl = 1'b0;
        bus.lcd_s   = 1'b0;
        bus.lcd_ld  = 2'b00;
        tick(3);
        check_idle("reset_outputs");
        reset_n = 1'b1;
        tick(2);
        check_idle("post_reset_outputs");

        // Activity before any S-qualified CPL must be ignored.
        repeat (3) cp_px();
        st_pulse();
        cpl_pulse(1'b0);

        // Sync, then one full frame whose last line end carries S.
        cpl_pulse(1'b1);
        for (int l = 0; l < H; l++) line(W, (l == H - 1));

        line(W - 2, 1'b0);          // short line
        line(W + 2, 1'b0);          // overrun twice
        st_pulse();                 // pixel and line end in the same clk
        repeat (W - 1) cp_px();
        cp_cpl_same(1'b0);

        st_pulse();                 // ST restart mid-line
        repeat (5) cp_px();
        line(W, 1'b0);
        cpl_pulse(1'b0);            // empty line from LWAIT

        // Lose vsync: S never arrives, capture halts until it does.
        cpl_pulse(1'b1);
        for (int l = 0; l < H; l++) line(W, 1'b0);
        repeat (4) cp_px();
        line(3, 1'b0);
        cpl_pulse(1'b1);
        line(W, 1'b0);

        // Reset in the middle of a line.
        line(W, 1'b0);
        st_pulse();
        repeat (8) cp_px();
        tick(6);
        check_drained("drain_before_reset");
        reset_n = 1'b0;
        #1;
        check_idle("async_reset_outputs");
        mode = M_HUNT;
        mx = 0;
        my = 0;
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        tick(2);
        repeat (4) cp_px();
        line(5, 1'b0);
        cpl_pulse(1'b1);
        line(W, 1'b0);
        line(W, 1'b0);

        tick(10);
        check_drained("final_drain");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
